// File: rtl/piso_pkg.sv
// Shared types and constants for the piso_tx serial transmitter.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/bit_tick.sv
// Bit-period divider: one-cycle tick at the end of every DIV-cycle bit period.
module bit_tick
  import piso_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic ret,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (clog2(DIV) < 1) ? 1 : clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] div_cnt;

  always_ff @(posedge clk or posedge ret) begin
    if (ret) begin
      div_cnt <= '0;
    end else if (clr) begin
      div_cnt <= '0;
    end else if (en) begin
      div_cnt <= (div_cnt == LAST) ? '0 : div_cnt + 1'b1;
    end
  end

  // With DIV=1 the counter sits at 0 and every enabled cycle is a tick.
  assign tick = en && !clr && (div_cnt == LAST);

endmodule

// File: rtl/piso_tx.sv
// Framed parallel-in/serial-out transmitter: start bit, WIDTH data bits LSB-first
// (optionally inverted for the inverting receiver), stop bit; DIV clocks per bit.
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 4,
  parameter bit INV   = 1'b1
) (
  input  logic             clk,
  input  logic             ret,
  input  logic             pre,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam int BW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shifted;
  logic [BW-1:0]    bit_cnt;
  logic             accept;
  logic             tick;

  assign accept  = (state == IDLE) && load && !pre;
  assign shifted = shreg >> 1;

  bit_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .ret  (ret),
    .clr  (pre || accept),
    .en   (state != IDLE),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge ret) begin
    if (ret) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      sout    <= IDLE_LEVEL;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (pre) begin
        state   <= IDLE;
        bit_cnt <= '0;
        sout    <= IDLE_LEVEL;
        busy    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (load) begin
              shreg   <= din;
              bit_cnt <= '0;
              state   <= START;
              sout    <= START_LEVEL;
              busy    <= 1'b1;
            end
          end
          START: begin
            if (tick) begin
              state <= DATA;
              sout  <= shreg[0] ^ INV;
            end
          end
          DATA: begin
            // Shift so the next data bit is always at shreg[0].
            if (tick) begin
              shreg <= shifted;
              if (bit_cnt == BIT_LAST) begin
                state   <= STOP;
                bit_cnt <= '0;
                sout    <= IDLE_LEVEL;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                sout    <= shifted[0] ^ INV;
              end
            end
          end
          STOP: begin
            if (tick) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: frame-level reference model for WIDTH=8/DIV=4 (INV=0 and 1),
// plus a cycle table for WIDTH=4/DIV=1.
module tb_piso_tx;

  logic       clk = 1'b0;
  logic       ret = 1'b1;
  logic       pre_ab = 1'b0, load_ab = 1'b0;
  logic [7:0] din_ab = 8'h00;
  logic       a_sout, a_busy, a_done;
  logic       b_sout, b_busy, b_done;
  logic       pre_c = 1'b0, load_c = 1'b0;
  logic [3:0] din_c = 4'h0;
  logic       c_sout, c_busy, c_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  piso_tx #(.WIDTH(8), .DIV(4), .INV(1'b0)) dut_a (
    .clk(clk), .ret(ret), .pre(pre_ab), .load(load_ab), .din(din_ab),
    .sout(a_sout), .busy(a_busy), .done(a_done));

  piso_tx #(.WIDTH(8), .DIV(4), .INV(1'b1)) dut_b (
    .clk(clk), .ret(ret), .pre(pre_ab), .load(load_ab), .din(din_ab),
    .sout(b_sout), .busy(b_busy), .done(b_done));

  piso_tx #(.WIDTH(4), .DIV(1), .INV(1'b0)) dut_c (
    .clk(clk), .ret(ret), .pre(pre_c), .load(load_c), .din(din_c),
    .sout(c_sout), .busy(c_busy), .done(c_done));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is the bit list {start, data (xor inv), stop},
  // each bit lasting 4 clocks; m_t is the clock index inside the 40-clock frame.
  bit       m_busy = 1'b0;
  bit       m_done = 1'b0;
  int       m_t    = 0;
  bit [7:0] m_word = 8'h00;

  function automatic logic exp_sout(input bit inv);
    int idx;
    if (!m_busy) return 1'b1;
    idx = m_t / 4;
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return m_word[idx-1] ^ inv;
  endfunction

  task automatic step_ab();
    bit       r = ret;
    bit       p = pre_ab;
    bit       l = load_ab;
    bit [7:0] d = din_ab;
    @(posedge clk);
    #1;
    if (r || p) begin
      m_busy = 1'b0;
      m_done = 1'b0;
    end else if (m_busy) begin
      m_t++;
      m_done = 1'b0;
      if (m_t == 40) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end else begin
      m_done = 1'b0;
      if (l) begin
        m_busy = 1'b1;
        m_t    = 0;
        m_word = d;
      end
    end
    check("a_sout", 32'(a_sout), 32'(exp_sout(1'b0)));
    check("a_busy", 32'(a_busy), 32'(m_busy));
    check("a_done", 32'(a_done), 32'(m_done));
    check("b_sout", 32'(b_sout), 32'(exp_sout(1'b1)));
    check("b_done", 32'(b_done), 32'(m_done));
  endtask

  typedef struct packed {
    logic       load;
    logic [3:0] din;
    logic       pre;
    logic       sout;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t tbl [21];

  logic [7:0] rec_a, rec_b;
  int         idx;

  initial begin
    tbl[0]  = '{1'b1, 4'h6, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 4'h9, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 4'h9, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 4'h9, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[16] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[17] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[18] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[19] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[20] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0};

    // Reset held over two edges, then released
    step_ab();
    step_ab();
    check("c_rst_sout", 32'(c_sout), 32'd1);
    check("c_rst_busy", 32'(c_busy), 32'd0);
    ret = 1'b0;
    step_ab();

    // 8'hA5 frame; both receivers' view must recover the word
    rec_a = 8'h00;
    rec_b = 8'h00;
    load_ab = 1'b1;
    din_ab  = 8'hA5;
    step_ab();
    load_ab = 1'b0;
    din_ab  = 8'h00;
    for (int i = 0; i < 44; i++) begin
      if (m_busy && (m_t % 4 == 2) && (m_t / 4 >= 1) && (m_t / 4 <= 8)) begin
        idx = m_t / 4 - 1;
        rec_a[idx] = a_sout;
        rec_b[idx] = ~b_sout;
      end
      step_ab();
    end
    check("rx_true", 32'(rec_a), 32'h0000_00A5);
    check("rx_inverted", 32'(rec_b), 32'h0000_00A5);

    // load held high: 3C then C3 back to back
    load_ab = 1'b1;
    din_ab  = 8'h3C;
    step_ab();
    din_ab = 8'hC3;
    for (int i = 0; i < 85; i++) step_ab();
    load_ab = 1'b0;
    for (int i = 0; i < 45; i++) step_ab();

    // pre during the third data bit, then a fresh frame
    load_ab = 1'b1;
    din_ab  = 8'h5A;
    step_ab();
    load_ab = 1'b0;
    for (int i = 0; i < 13; i++) step_ab();
    pre_ab = 1'b1;
    step_ab();
    check("pre_busy", 32'(a_busy), 32'd0);
    pre_ab = 1'b0;
    for (int i = 0; i < 3; i++) step_ab();
    pre_ab  = 1'b1;
    load_ab = 1'b1;
    step_ab();
    pre_ab = 1'b0;
    step_ab();
    load_ab = 1'b0;
    for (int i = 0; i < 42; i++) step_ab();

    // Random load/din/pre traffic
    for (int i = 0; i < 1500; i++) begin
      load_ab = ($urandom_range(7) == 0);
      din_ab  = 8'($urandom);
      pre_ab  = ($urandom_range(63) == 0);
      step_ab();
    end
    load_ab = 1'b0;
    pre_ab  = 1'b0;

    // Asynchronous reset mid-frame, between edges
    load_ab = 1'b1;
    din_ab  = 8'hFF;
    step_ab();
    load_ab = 1'b0;
    for (int i = 0; i < 10; i++) step_ab();
    #3;
    ret = 1'b1;
    #1;
    check("async_a_sout", 32'(a_sout), 32'd1);
    check("async_a_busy", 32'(a_busy), 32'd0);
    check("async_b_sout", 32'(b_sout), 32'd1);
    m_busy = 1'b0;
    m_done = 1'b0;
    step_ab();
    ret = 1'b0;
    for (int i = 0; i < 6; i++) step_ab();

    // WIDTH=4, DIV=1 cycle table
    for (int i = 0; i < 21; i++) begin
      load_c = tbl[i].load;
      din_c  = tbl[i].din;
      pre_c  = tbl[i].pre;
      @(posedge clk);
      #1;
      check($sformatf("c_sout[%0d]", i), 32'(c_sout), 32'(tbl[i].sout));
      check($sformatf("c_busy[%0d]", i), 32'(c_busy), 32'(tbl[i].busy));
      check($sformatf("c_done[%0d]", i), 32'(c_done), 32'(tbl[i].done));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
